// File: rtl/spi_eeprom_pkg.sv
// spi_eeprom_pkg: shared opcodes, FSM encoding and status helper
// for the 25xx-style SPI EEPROM responder.
package spi_eeprom_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_READ,
    ST_WRITE,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b0, wel, 1'b0};
  endfunction

endpackage

// File: rtl/spi_eeprom_ram.sv
// spi_eeprom_ram: single-port byte RAM, synchronous read (1 clk).
// Ports: clk, we_i, addr_i, wdata_i -> rdata_o (registered).
module spi_eeprom_ram
  import spi_eeprom_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: SPI slave emulating a 25xx EEPROM.
// Ports: clk, reset(n), spi_clk/mosi/ss in; miso/miso_oe/wel/busy out.
module spi_eeprom_responder
  import spi_eeprom_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic mosi,
  input  logic ss,
  output logic miso,
  output logic miso_oe,
  output logic wel,
  output logic busy
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sck_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q  <= '1;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sck_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, mosi_s, ss_s;
  logic rise, fall;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;

  state_t            state_q;
  logic [2:0]        bit_ctr_q;
  logic [6:0]        rx_q;
  logic              is_write_q;
  logic [7:0]        addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_q;
  logic [2:0]        tx_ctr_q;
  logic              rd_q;
  logic              ld_q;
  logic              we_q;
  logic              inc_q;
  logic [7:0]        wdata_q;
  logic              miso_q;
  logic              oe_q;
  logic              wel_q;
  logic              busy_q;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_inc_d;
  logic [7:0]        ram_rdata;

  assign rx_byte    = {rx_q, mosi_s};
  assign addr_inc_d = addr_q + ADDR_W'(1);

  spi_eeprom_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_ctr_q  <= '0;
      rx_q       <= '0;
      is_write_q <= 1'b0;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      tx_ctr_q   <= '0;
      rd_q       <= 1'b0;
      ld_q       <= 1'b0;
      we_q       <= 1'b0;
      inc_q      <= 1'b0;
      wdata_q    <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wel_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= ~ss_s;
      rd_q   <= 1'b0;
      ld_q   <= rd_q;
      we_q   <= 1'b0;
      inc_q  <= 1'b0;
      // RAM data arrives two clk after a read request
      if (ld_q)
        tx_q <= ram_rdata;
      // Write lands at the old address, then it advances
      if (inc_q)
        addr_q <= addr_inc_d;

      if (ss_s) begin
        state_q    <= ST_IDLE;
        bit_ctr_q  <= '0;
        tx_ctr_q   <= '0;
        oe_q       <= 1'b0;
        miso_q     <= 1'b0;
        ld_q       <= 1'b0;
        is_write_q <= 1'b0;
        if (is_write_q)
          wel_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
        state_q   <= ST_CMD;
        bit_ctr_q <= '0;
        tx_ctr_q  <= '0;
      end else if (rise) begin
        rx_q      <= rx_byte[6:0];
        bit_ctr_q <= bit_ctr_q + 3'd1;
        if (bit_ctr_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              is_write_q <= (rx_byte == CMD_WRITE);
              unique case (1'b1)
                (rx_byte == CMD_READ),
                (rx_byte == CMD_WRITE): state_q <= ST_ADDR_HI;
                (rx_byte == CMD_WREN): begin
                  wel_q   <= 1'b1;
                  state_q <= ST_IGNORE;
                end
                (rx_byte == CMD_WRDI): begin
                  wel_q   <= 1'b0;
                  state_q <= ST_IGNORE;
                end
                (rx_byte == CMD_RDSR): begin
                  tx_q     <= status_byte(wel_q);
                  tx_ctr_q <= '0;
                  state_q  <= ST_STATUS;
                end
                default: state_q <= ST_IGNORE;
              endcase
            end
            ST_ADDR_HI: begin
              addr_hi_q <= rx_byte;
              state_q   <= ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
              addr_q   <= ADDR_W'({addr_hi_q, rx_byte});
              tx_ctr_q <= '0;
              if (is_write_q) begin
                state_q <= ST_WRITE;
              end else begin
                state_q <= ST_READ;
                rd_q    <= 1'b1;
              end
            end
            ST_WRITE: begin
              we_q    <= wel_q;
              wdata_q <= rx_byte;
              inc_q   <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (fall) begin
        case (state_q)
          ST_READ, ST_STATUS: begin
            miso_q   <= tx_q[7];
            oe_q     <= 1'b1;
            tx_ctr_q <= tx_ctr_q + 3'd1;
            if (tx_ctr_q != 3'd7)
              tx_q <= {tx_q[6:0], 1'b0};
            else if (state_q == ST_STATUS)
              tx_q <= status_byte(wel_q);
            else begin
              // Last bit of the byte is out: prefetch the next one
              addr_q <= addr_inc_d;
              rd_q   <= 1'b1;
            end
          end
          default: begin
            oe_q   <= 1'b0;
            miso_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign wel     = wel_q;
  assign busy    = busy_q;

endmodule
